// File: rtl/rotary_quad_gen.sv
// Quadrature (ck/dt) waveform generator. It emits one full Gray-code cycle per detent for a signed step command.
// Define ROTARY_QUAD_GEN_POS_EN to add a signed 16-bit detent position output.
module rotary_quad_gen #(
  parameter int PHASE_CYCLES = 2000,
  parameter int GAP_CYCLES   = 0,
  parameter int WIDTH        = 8
) (
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [WIDTH-1:0] cmd_steps,
  input  logic                    abort,
  output logic                    ck,
  output logic                    dt,
  output logic                    busy,
  output logic [WIDTH-1:0]        remaining
`ifdef ROTARY_QUAD_GEN_POS_EN
  ,
  output logic signed [15:0]      position
`endif
);

  localparam int CNT_W = $clog2(PHASE_CYCLES + GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] PH_LOAD  = CNT_W'(PHASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DET_LOAD = CNT_W'(PHASE_CYCLES + GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    DET
  } state_t;

  state_t           state;
  logic             dir_bwd;
  logic             abort_q;
  logic [CNT_W-1:0] phase_cnt;
  logic [WIDTH-1:0] magnitude;
  logic             det_entry;

  // Two's-complement negation of the most negative value yields the same bit pattern.
  // Read as unsigned, that pattern is the correct magnitude (e.g. -128 -> 128).
  assign magnitude = cmd_steps[WIDTH-1] ? $unsigned(-cmd_steps) : $unsigned(cmd_steps);

  assign cmd_ready = !busy;
  assign det_entry = (state == PH3) && (phase_cnt == '0);

  // The (ck,dt) pattern for each phase. The middle phase is 11 in both directions.
  function automatic logic [1:0] phase_pattern(input state_t s, input logic bwd);
    case (s)
      PH1:     return bwd ? 2'b01 : 2'b10;
      PH2:     return 2'b11;
      PH3:     return bwd ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ck        <= 1'b0;
      dt        <= 1'b0;
      remaining <= '0;
      dir_bwd   <= 1'b0;
      abort_q   <= 1'b0;
      phase_cnt <= '0;
    end else begin
      if (busy && abort) begin
        abort_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (!busy) begin
            if (cmd_valid) begin
              dir_bwd   <= cmd_steps[WIDTH-1];
              remaining <= magnitude;
              busy      <= 1'b1;
            end
          end else if (remaining != '0) begin
            state     <= PH1;
            {ck, dt}  <= phase_pattern(PH1, dir_bwd);
            phase_cnt <= PH_LOAD;
          end else begin
            // A zero-step command: release after a single busy clock.
            busy      <= 1'b0;
            abort_q   <= 1'b0;
            remaining <= '0;
            phase_cnt <= '0;
          end
        end

        PH1, PH2: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else begin
            state     <= (state == PH1) ? PH2 : PH3;
            {ck, dt}  <= phase_pattern((state == PH1) ? PH2 : PH3, dir_bwd);
            phase_cnt <= PH_LOAD;
          end
        end

        PH3: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else begin
            state     <= DET;
            {ck, dt}  <= 2'b00;
            remaining <= remaining - 1'b1;
            phase_cnt <= DET_LOAD;
          end
        end

        DET: begin
          if (phase_cnt != '0) begin
            phase_cnt <= phase_cnt - 1'b1;
          end else if (remaining != '0 && !abort_q) begin
            state     <= PH1;
            {ck, dt}  <= phase_pattern(PH1, dir_bwd);
            phase_cnt <= PH_LOAD;
          end else begin
            // An abort takes effect only here, once the step in flight has fully settled at 00.
            state     <= IDLE;
            busy      <= 1'b0;
            remaining <= '0;
            abort_q   <= 1'b0;
            phase_cnt <= '0;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          {ck, dt}  <= 2'b00;
          remaining <= '0;
          abort_q   <= 1'b0;
          phase_cnt <= '0;
        end
      endcase
    end
  end

`ifdef ROTARY_QUAD_GEN_POS_EN
  // Detent position survives commands and aborts. Only reset clears it, and it wraps freely.
  always_ff @(posedge aclk or negedge reset) begin
    if (!reset) begin
      position <= '0;
    end else if (det_entry) begin
      position <= dir_bwd ? position - 16'sd1 : position + 16'sd1;
    end
  end
`endif

endmodule

// File: tb/tb_rotary_quad_gen.sv
// Directed bench for rotary_quad_gen with PHASE_CYCLES=4 and GAP_CYCLES=2, giving an 18-clock step period.
// Outputs are sampled 1 ns after each rising edge.
module tb_rotary_quad_gen;

  logic              aclk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic signed [7:0] cmd_steps;
  logic              abort;
  logic              ck;
  logic              dt;
  logic              busy;
  logic [7:0]        remaining;
`ifdef ROTARY_QUAD_GEN_POS_EN
  logic signed [15:0] position;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rotary_quad_gen #(
    .PHASE_CYCLES(4),
    .GAP_CYCLES  (2),
    .WIDTH       (8)
  ) dut (
    .aclk     (aclk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .ck       (ck),
    .dt       (dt),
    .busy     (busy),
    .remaining(remaining)
`ifdef ROTARY_QUAD_GEN_POS_EN
    ,
    .position (position)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  // Presents a command for exactly one edge (E0) and returns 1 ns after it.
  task automatic accept(input logic [7:0] steps);
    cmd_steps = steps;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int  cnt;
    int  rises;
    logic ck_prev;
    logic ck_seen;

    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    abort     = 1'b0;

    // 1. Reset state, then release.
    #12;
    check("rst_ckdt", {ck, dt}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_remaining", remaining, 8'd0);
    tick(1);
    reset = 1'b1;
    tick(2);
    check("idle_ckdt", {ck, dt}, 2'b00);
    check("idle_ready", cmd_ready, 1'b1);
    check("idle_remaining", remaining, 8'd0);

    // 2. +1 step.
    accept(8'sd1);
    check("p1_e0_busy", busy, 1'b1);
    check("p1_e0_ready", cmd_ready, 1'b0);
    check("p1_e0_remaining", remaining, 8'd1);
    check("p1_e0_ckdt", {ck, dt}, 2'b00);
    tick(1);
    check("p1_e1_ckdt", {ck, dt}, 2'b10);
    tick(4);
    check("p1_e5_ckdt", {ck, dt}, 2'b11);
    tick(4);
    check("p1_e9_ckdt", {ck, dt}, 2'b01);
    tick(4);
    check("p1_e13_ckdt", {ck, dt}, 2'b00);
    check("p1_e13_remaining", remaining, 8'd0);
    tick(5);
    check("p1_e18_busy", busy, 1'b1);
    tick(1);
    check("p1_e19_busy", busy, 1'b0);
    check("p1_e19_ready", cmd_ready, 1'b1);

    // 1b. Asynchronous reset in the middle of PH2.
    accept(8'sd1);
    tick(6);
    check("mid_ph2_ckdt", {ck, dt}, 2'b11);
    reset = 1'b0;
    #1;
    check("async_rst_ckdt", {ck, dt}, 2'b00);
    check("async_rst_ready", cmd_ready, 1'b1);
    check("async_rst_remaining", remaining, 8'd0);
    #1;
    reset = 1'b1;
    tick(2);

    // 3. -2 steps; a command offered while busy must be ignored.
    accept(-8'sd2);
    check("m2_e0_remaining", remaining, 8'd2);
    tick(1);
    check("m2_e1_ckdt", {ck, dt}, 2'b01);
    tick(4);
    check("m2_e5_ckdt", {ck, dt}, 2'b11);
    tick(4);
    check("m2_e9_ckdt", {ck, dt}, 2'b10);
    tick(4);
    check("m2_e13_ckdt", {ck, dt}, 2'b00);
    check("m2_e13_remaining", remaining, 8'd1);
    cmd_steps = 8'sd5;
    cmd_valid = 1'b1;
    tick(3);
    cmd_valid = 1'b0;
    check("m2_ignored_remaining", remaining, 8'd1);
    tick(3);
    check("m2_e19_ckdt", {ck, dt}, 2'b01);
    tick(4);
    check("m2_e23_ckdt", {ck, dt}, 2'b11);
    tick(4);
    check("m2_e27_ckdt", {ck, dt}, 2'b10);
    tick(4);
    check("m2_e31_ckdt", {ck, dt}, 2'b00);
    check("m2_e31_remaining", remaining, 8'd0);
    tick(5);
    check("m2_e36_busy", busy, 1'b1);
    tick(1);
    check("m2_e37_busy", busy, 1'b0);
    check("m2_e37_remaining", remaining, 8'd0);

    // 4. Zero-step command.
    accept(8'sd0);
    check("z_e0_busy", busy, 1'b1);
    check("z_e0_remaining", remaining, 8'd0);
    tick(1);
    check("z_e1_busy", busy, 1'b0);
    check("z_e1_ready", cmd_ready, 1'b1);
    ck_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ck_seen = ck_seen | ck | dt;
      tick(1);
    end
    check("z_no_toggle", ck_seen, 1'b0);

    // 5. +3 steps, with an abort during PH2 of the first step.
    accept(8'sd3);
    tick(1);
    check("ab_e1_ckdt", {ck, dt}, 2'b10);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(6);
    check("ab_e13_ckdt", {ck, dt}, 2'b00);
    check("ab_e13_remaining", remaining, 8'd2);
    tick(5);
    check("ab_e18_busy", busy, 1'b1);
    tick(1);
    check("ab_e19_busy", busy, 1'b0);
    check("ab_e19_remaining", remaining, 8'd0);
    ck_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ck_seen = ck_seen | ck;
      tick(1);
    end
    check("ab_no_more_ck", ck_seen, 1'b0);

    // 6. -128 steps; reset first so position starts from 0.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick(2);
    accept(8'h80);
    check("m128_remaining", remaining, 8'h80);
    tick(1);
    check("m128_e1_ckdt", {ck, dt}, 2'b01);
    cnt     = 0;
    rises   = 0;
    ck_prev = ck;
    while (busy && cnt < 3000) begin
      tick(1);
      cnt++;
      if (ck && !ck_prev) rises++;
      ck_prev = ck;
    end
    check("m128_clocks", cnt, 2304);
    check("m128_cycles", rises, 128);
    check("m128_remaining_end", remaining, 8'd0);
`ifdef ROTARY_QUAD_GEN_POS_EN
    check("m128_position", {16'h0, position}, 32'h0000_ff80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotary_quad_gen.md
Name: rotary_quad_gen

Overview:
- Quadrature waveform generator: the transmit side of the rotary-encoder interface.
- Takes a signed step command and drives ck/dt through Gray-code sequences, one full 4-phase cycle per detent.
- Each phase is held long enough to pass the rotary_enc debounce.
- Used in loopback tests of rotary_enc and as a front-panel encoder emulator driven by firmware.

Parameters:
- PHASE_CYCLES, 2000: clocks each ck/dt pattern is held; must be >= 1, and > the decoder's CYCLES in loopback.
- GAP_CYCLES, 0: extra idle clocks at detent (00) after each step.
- WIDTH, 8: width of the signed step command.

Ports:
- aclk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  step command valid
- cmd_ready  out  1  generator can accept a command
- cmd_steps  in  WIDTH  signed step count; positive = forward, negative = backward
- abort  in  1  stop at the next detent
- ck  out  1  quadrature channel A
- dt  out  1  quadrature channel B
- busy  out  1  command in progress
- remaining  out  WIDTH  unsigned count of steps still to emit

Behaviour:
- Reset (reset=0, asynchronous):
  - ck=0, dt=0, busy=0, cmd_ready=1, remaining=0, FSM=IDLE.
  - Takes effect immediately, including mid-phase; the step in flight is discarded.
- Handshake:
  - cmd_ready = !busy, combinational from the register.
  - A command is accepted on an edge with cmd_valid && cmd_ready.
  - cmd_valid while busy is ignored; no queueing.
- Accept edge E0:
  - Latch dir = sign bit and magnitude = |cmd_steps| as unsigned WIDTH bits. The most negative value (-128 at WIDTH=8) gives magnitude 128.
  - remaining <= magnitude; busy <= 1; ck/dt stay 00.
- Zero step command: busy is high for exactly one clock (E0 to E1), there are no ck/dt edges, and remaining stays 0.
- Patterns, listed as (ck,dt):
  - Forward: 00 -> 10 -> 11 -> 01 -> 00.
  - Backward: 00 -> 01 -> 11 -> 10 -> 00.
  - Exactly one output changes per transition; no glitches, since ck and dt are driven from registers.
- FSM states: IDLE, PH1, PH2, PH3, DET.
  - E1: IDLE -> PH1, pattern p1.
  - E1+P: PH2, pattern p2.
  - E1+2P: PH3, pattern p3.
  - E1+3P: DET, pattern 00; remaining decrements on this same edge.
  - DET holds for P+GAP_CYCLES clocks. It then goes to PH1 if remaining != 0 and no abort is latched; otherwise it goes to IDLE with busy <= 0.
  - Step period = 4*P + GAP_CYCLES.
- Abort:
  - Latched on any edge while busy.
  - The step in progress always completes to 00 and its DET hold.
  - At the IDLE transition, remaining <= 0 and the abort latch clears.
  - Abort while idle has no effect.
  - Abort on the accept edge: the first step still runs in full.
- Phase counter:
  - Sized by $clog2(PHASE_CYCLES+GAP_CYCLES+1).
  - Reloads on every FSM transition; never wraps.

Optional Feature:
- Macro: ROTARY_QUAD_GEN_POS_EN.
- When defined, adds output position (signed 16 bits, reset 0):
  - +1 on each forward DET entry, -1 on each backward DET entry.
  - Wraps two's-complement (32767 + 1 -> -32768).
  - Not cleared by commands or abort; only reset clears it.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
(All with PHASE_CYCLES=4, GAP_CYCLES=2.)
1. Reset, then release -> ck=0, dt=0, busy=0, cmd_ready=1, remaining=0. Reset pulsed mid-PH2 -> ck/dt=00 within the same clock and cmd_ready=1.
2. cmd_steps=+1 accepted at E0:
   - (ck,dt) = 10 at E1, 11 at E5, 01 at E9, 00 at E13.
   - remaining 1 -> 0 at E13.
   - busy falls at E19.
3. cmd_steps=-2:
   - Pattern 01, 11, 10, 00 runs twice, 18-clock period.
   - remaining 2 -> 1 -> 0.
   - cmd_valid during busy is ignored.
4. cmd_steps=0 -> busy high for one clock, no ck/dt toggles, cmd_ready back at E1.
5. cmd_steps=+3, abort pulsed during the PH2 of step 1:
   - Step 1 completes to 00 and remaining reads 2.
   - After the DET hold, remaining becomes 0 and busy becomes 0.
   - No further ck edges.
6. cmd_steps=-128:
   - Exactly 128 backward cycles, 2304 clocks from E1 to busy falling.
   - With ROTARY_QUAD_GEN_POS_EN defined, position ends at -128.
